// File: rtl/act_seq_ctrl.sv
// act_seq_ctrl: command-driven sequencer that streams a contiguous block of signed elements
// from a source buffer through an activation unit (linear / ReLU) into a destination buffer.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake (ready only while idle)
//   cmd_select                  0 = linear, 1 = ReLU (captured on accept)
//   cmd_src, cmd_dst, cmd_len   first source/destination address, element count (0..2^ADDR_W)
//   rd_en, rd_addr, rd_data     source read port, data returns the cycle after rd_en
//   act_start, act_select,
//   act_buffer, act_result      activation unit interface (result valid the cycle after start)
//   wr_en, wr_addr, wr_data     destination write port, always accepted
//   busy, done                  command in progress, one-cycle completion pulse
//   neg_count                   negative inputs clipped by the last ReLU command
module act_seq_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_select,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              act_start,
  output logic              act_select,
  output logic [DATA_W-1:0] act_buffer,
  input  logic [DATA_W-1:0] act_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   neg_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   remain_q;   // reads still to issue after the current one
  logic [ADDR_W-1:0] wr_ptr_q;   // next destination address
  logic              sel_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              act_start_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W:0]   neg_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remain_q    <= '0;
      wr_ptr_q    <= '0;
      sel_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      act_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      neg_count_q <= '0;
    end else begin
      // Fixed-latency pipeline: read -> activation start -> write.
      act_start_q <= rd_en_q;
      wr_en_q     <= act_start_q;
      if (act_start_q) begin
        wr_addr_q <= wr_ptr_q;
        wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
        if (sel_q && rd_data[DATA_W-1]) begin
          neg_count_q <= neg_count_q + (ADDR_W+1)'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            sel_q       <= cmd_select;
            wr_ptr_q    <= cmd_dst;
            neg_count_q <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StRun;
              rd_en_q   <= 1'b1;
              rd_addr_q <= cmd_src;
              remain_q  <= cmd_len - (ADDR_W+1)'(1);
            end
          end
        end
        StRun: begin
          if (remain_q == '0) begin
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            remain_q  <= remain_q - (ADDR_W+1)'(1);
          end
        end
        StDrain: begin
          // With no activation start in flight, the current cycle carries the last write.
          if (!act_start_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign act_start  = act_start_q;
  assign act_select = sel_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign neg_count  = neg_count_q;

  // Data paths pass straight through; gating keeps them at zero outside their valid cycles.
  assign act_buffer = act_start_q ? rd_data : '0;
  assign wr_data    = wr_en_q ? act_result : '0;

endmodule
